uart_mem_responder: RTL



---
 rtl/uart_mem_responder_pkg.sv | 22 ++
 rtl/uart_mem_responder_resp_mem.sv | 37 +++
 rtl/uart_mem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_mem_responder_pkg.sv
// Shared definitions for the bitty byte-serial load/store link: flag bytes, default widths and
// the responder state encoding.
package uart_mem_responder_pkg;

  localparam int unsigned DefaultDataW = 16;
  localparam int unsigned DefaultAddrW = 8;

  localparam logic [7:0] FLAG_LOAD  = 8'h01;
  localparam logic [7:0] FLAG_STORE = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StRead,
    StSendHigh,
    StSendLow,
    StGetHigh,
    StGetLow,
    StWrite
  } resp_state_e;

endpackage

// File: rtl/uart_mem_responder_resp_mem.sv
// Single-port word RAM for the responder: synchronous write, registered read.
// Only the read register is reset; the array contents are not.
module uart_mem_responder_resp_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_mem_responder.sv
// Memory-side responder for the bitty load/store link: decodes flag/address/data bytes from the
// UART receiver and serves loads/stores. Define UART_RESP_ERRCNT_EN to add the err_count port.
module uart_mem_responder
  import uart_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
`ifdef UART_RESP_ERRCNT_EN
  ,
  parameter int unsigned ERR_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_do,
  input  logic [7:0]       rx_data,
  input  logic             tx_done,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             wr_strobe
`ifdef UART_RESP_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_count
`endif
);

  resp_state_e       state_q, state_d;
  logic              op_store_q, op_store_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic              tx_start_q;
  logic              wr_strobe_q;

  always_comb begin
    state_d    = state_q;
    op_store_d = op_store_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      StIdle: begin
        if (rx_do) begin
          if (rx_data == FLAG_LOAD) begin
            op_store_d = 1'b0;
            state_d    = StGetAddr;
          end else if (rx_data == FLAG_STORE) begin
            op_store_d = 1'b1;
            state_d    = StGetAddr;
          end
        end
      end
      StGetAddr: begin
        if (rx_do) begin
          addr_d  = rx_data[ADDR_W-1:0];
          state_d = op_store_q ? StGetHigh : StRead;
        end
      end
      StRead:     state_d = StSendHigh;
      StSendHigh: if (tx_done) state_d = StSendLow;
      StSendLow:  if (tx_done) state_d = StIdle;
      StGetHigh: begin
        if (rx_do) begin
          wdata_d[DATA_W-1 -: 8] = rx_data;
          state_d                = StGetLow;
        end
      end
      StGetLow: begin
        if (rx_do) begin
          wdata_d[7:0] = rx_data;
          state_d      = StWrite;
        end
      end
      StWrite:    state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      op_store_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_start_q  <= 1'b1;
      wr_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_store_q  <= op_store_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      // Held low across both SEND states so there is no idle gap between the two bytes.
      tx_start_q  <= !((state_d == StSendHigh) || (state_d == StSendLow));
      wr_strobe_q <= (state_d == StWrite);
    end
  end

  uart_mem_responder_resp_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_resp_mem (
    .clk  (clk),
    .reset(reset),
    .re   (state_q == StRead),
    .we   (state_q == StWrite),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(rdata_q)
  );

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      StSendHigh: tx_data = rdata_q[DATA_W-1 -: 8];
      StSendLow:  tx_data = rdata_q[7:0];
      default:    tx_data = 8'h00;
    endcase
  end

  assign tx_start  = tx_start_q;
  assign wr_strobe = wr_strobe_q;
  assign busy      = (state_q != StIdle);

`ifdef UART_RESP_ERRCNT_EN
  logic [ERR_W-1:0] err_count_q;
  logic             bad_flag;

  assign bad_flag = (state_q == StIdle) && rx_do &&
                    (rx_data != FLAG_LOAD) && (rx_data != FLAG_STORE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count_q <= '0;
    end else if (bad_flag && (err_count_q != '1)) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule
